can_rx_destuff: RTL and testbench
=================================

Name: can_rx_destuff

Overview:
- Receive-side bit-stream stage placed directly downstream of can_bit_timing.
- Consumes its sample strobe and sampled bus bit.
- Removes stuff bits and flags stuff errors.
- Accumulates CRC-15 over de-stuffed bits and detects bus idle (11 consecutive recessive bits) for the frame decoder / bus-integration logic.

Parameters:
- STUFF_LEN, 5, consecutive equal bits after which the next bit is a stuff bit.
- IDLE_BITS, 11, consecutive recessive samples required to declare bus idle.
- CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial (x^15 term implicit).

Ports:
- i_can_clk  in  1  CAN core clock (same clock as can_bit_timing).
- i_reset  in  1  reset, asynchronous, active-low (asserted at 0).
- i_samp_tick  in  1  one-cycle sample strobe from can_bit_timing o_samp_tick.
- i_rx_bit  in  1  sampled bus bit from can_bit_timing o_rx_bit; 1 = recessive.
- i_destuff_en  in  1  frame decoder: current bit lies in the stuffed region (SOF..CRC sequence).
- i_crc_en  in  1  accumulate de-stuffed bits into CRC.
- i_crc_clr  in  1  synchronous clear of CRC register.
- i_err_clr  in  1  synchronous clear of sticky stuff error.
- o_bit_valid  out  1  one-cycle strobe: o_bit holds a de-stuffed data bit.
- o_bit  out  1  de-stuffed bit.
- o_stuff_bit  out  1  one-cycle strobe: the sampled bit was removed as a stuff bit.
- o_stuff_err  out  1  sticky stuff-rule violation.
- o_crc  out  15  running CRC register.
- o_crc_zero  out  1  o_crc == 0; combinational from the register.
- o_bus_idle  out  1  at least IDLE_BITS consecutive recessive samples seen.

Behaviour:
- Reset (i_reset = 0, async) values:
  - o_bit_valid = 0, o_bit = 1, o_stuff_bit = 0, o_stuff_err = 0, o_crc = 0, o_bus_idle = 0.
  - run_cnt = 0, run_val = 1, idle_cnt = 0.
- Reset mid-frame discards all state. No pending strobe survives reset release.
- All logic advances only on cycles with i_samp_tick = 1. Outputs are registered, so strobes appear 1 clk after the tick.
- Destuff counter, 3-bit run_cnt (0..STUFF_LEN) and run_val:
  - i_destuff_en = 0: run_cnt forced to 0. Every tick emits o_bit_valid with o_bit = i_rx_bit. No stuff checks.
  - i_destuff_en = 1 and run_cnt < STUFF_LEN: emit data bit.
    - If run_cnt == 0 or i_rx_bit != run_val: run_cnt <= 1, run_val <= i_rx_bit.
    - Otherwise run_cnt <= run_cnt + 1.
  - i_destuff_en = 1 and run_cnt == STUFF_LEN: the bit is a stuff bit. No o_bit_valid; o_stuff_bit pulses.
    - If i_rx_bit == run_val: o_stuff_err <= 1.
    - In either case run_cnt <= 1, run_val <= i_rx_bit. The stuff bit starts a new run.
- o_stuff_err stays set until i_err_clr = 1. If i_err_clr and a new violation occur on the same cycle, set wins.
- CRC-15, updated only for emitted data bits while i_crc_en = 1 (stuff bits never enter the CRC):
  - nxt = bit ^ crc[14];
  - crc <= {crc[13:0], 1'b0} ^ (nxt ? CRC_POLY : 0).
  - i_crc_clr has priority over an update on the same cycle: CRC becomes 0 and the bit is not accumulated.
- Bus idle, 4-bit idle_cnt, independent of i_destuff_en:
  - Recessive sample: increment, saturating at IDLE_BITS.
  - Dominant sample: clear to 0 and drop o_bus_idle on the following clk.
  - o_bus_idle = (idle_cnt == IDLE_BITS), registered.
- No handshake back-pressure. Downstream must accept every o_bit_valid strobe.

Decomposition:
- Shared package can_pkg: CAN_CRC_W = 15, CAN_CRC_POLY = 15'h4599, CAN_STUFF_LEN = 5, CAN_IDLE_BITS = 11. Module parameter defaults take these constants.
- One sub-module, can_crc15: clock, reset, i_clr, i_en, i_bit, o_crc. It is reused later by the transmit stuffer.
- Destuff counter and idle counter stay inline.

Test Plan:
- Destuff on, ticks with bits 0,0,0,0,0,1,1 -> 6 o_bit_valid strobes (0,0,0,0,0,1); the 6th sample raises o_stuff_bit; o_stuff_err = 0.
- Destuff on, six 0 samples -> 5 valid strobes; o_stuff_err = 1 one clk after the 6th tick and held. Then i_err_clr pulse -> 0.
- CRC: i_crc_clr, then a single data bit 1 with i_crc_en -> o_crc = 15'h4599.
  - Then feed the 15 bits of 0x4599, MSB first -> o_crc = 0 and o_crc_zero = 1.
- Bus idle: 10 recessive ticks -> o_bus_idle = 0; 11th tick -> 1 one clk later. One dominant tick -> 0. Counter saturates after 20 recessive ticks.
- Four 0s with destuff on, then i_reset low for 3 clks mid-stream -> all outputs return to reset values. After release, five 0s then 1 is handled as a fresh run: 1 is a stuff bit, no error.
- i_crc_clr and a data tick on the same cycle -> o_crc = 0; o_bit_valid still pulses.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN constants, bit classification type and the CRC-15 step function.
package can_pkg;

  localparam int                   CAN_CRC_W     = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY  = 15'h4599;
  localparam int                   CAN_STUFF_LEN = 5;
  localparam int                   CAN_IDLE_BITS = 11;

  // How a sampled bit is treated by the destuffer.
  typedef enum logic [1:0] {
    BIT_PASS,   // outside the stuffed region: forwarded unchecked
    BIT_DATA,   // inside the stuffed region: forwarded, extends the run
    BIT_STUFF   // inside the stuffed region: dropped, checked for polarity
  } bit_cls_e;

  // One serial CRC-15 step; the x^15 term of the polynomial is implicit.
  function automatic logic [CAN_CRC_W-1:0] crc15_step(
    input logic [CAN_CRC_W-1:0] crc,
    input logic                 b,
    input logic [CAN_CRC_W-1:0] poly
  );
    logic nxt;
    nxt = b ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (nxt ? poly : '0);
  endfunction

endpackage

// File: rtl/can_rx_destuff_if.sv
// Bit-stream bus between the bit-timing / frame-decoder side and the destuffer.
interface can_rx_destuff_if;
  import can_pkg::*;

  logic                 i_samp_tick;
  logic                 i_rx_bit;
  logic                 i_destuff_en;
  logic                 i_crc_en;
  logic                 i_crc_clr;
  logic                 i_err_clr;
  logic                 o_bit_valid;
  logic                 o_bit;
  logic                 o_stuff_bit;
  logic                 o_stuff_err;
  logic [CAN_CRC_W-1:0] o_crc;
  logic                 o_crc_zero;
  logic                 o_bus_idle;

  // Upstream / decoder side.
  modport master (
    output i_samp_tick, i_rx_bit, i_destuff_en, i_crc_en, i_crc_clr, i_err_clr,
    input  o_bit_valid, o_bit, o_stuff_bit, o_stuff_err, o_crc, o_crc_zero, o_bus_idle
  );

  // Destuffer side.
  modport slave (
    input  i_samp_tick, i_rx_bit, i_destuff_en, i_crc_en, i_crc_clr, i_err_clr,
    output o_bit_valid, o_bit, o_stuff_bit, o_stuff_err, o_crc, o_crc_zero, o_bus_idle
  );
endinterface

// File: rtl/can_crc15.sv
// Serial CRC-15 register with synchronous clear; shared by the RX and TX paths.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic                 i_can_clk,
  input  logic                 i_reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_bit,
  output logic [CAN_CRC_W-1:0] o_crc
);

  logic [CAN_CRC_W-1:0] crc_q, crc_d;

  // Clear beats accumulate so a bit arriving with the clear is not folded in.
  always_comb begin
    crc_d = crc_q;
    if (i_clr)     crc_d = '0;
    else if (i_en) crc_d = crc15_step(crc_q, i_bit, POLY);
  end

  // CRC state register.
  always_ff @(posedge i_can_clk or negedge i_reset) begin
    if (!i_reset) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/can_rx_destuff.sv
// CAN receive destuffer: drops stuff bits, flags stuff errors, runs CRC-15
// over the de-stuffed bits and watches for bus idle.
module can_rx_destuff
  import can_pkg::*;
#(
  parameter int                   STUFF_LEN = CAN_STUFF_LEN,
  parameter int                   IDLE_BITS = CAN_IDLE_BITS,
  parameter logic [CAN_CRC_W-1:0] CRC_POLY  = CAN_CRC_POLY
) (
  input  logic              i_can_clk,
  input  logic              i_reset,
  can_rx_destuff_if.slave   bus
);

  localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);
  localparam logic [3:0] IDLE_CNT  = 4'(IDLE_BITS);

  bit_cls_e             cls;
  logic [2:0]           run_cnt_q, run_cnt_d;
  logic                 run_val_q, run_val_d;
  logic [3:0]           idle_cnt_q, idle_cnt_d;
  logic                 bit_valid_q, bit_valid_d;
  logic                 bit_q, bit_d;
  logic                 stuff_bit_q, stuff_bit_d;
  logic                 stuff_err_q, stuff_err_d;
  logic                 bus_idle_q, bus_idle_d;
  logic                 viol;
  logic [CAN_CRC_W-1:0] crc;
  logic                 rx;

  assign rx = bus.i_rx_bit;

  // Classify the current sample: a full run inside the stuffed region means stuff bit.
  always_comb begin
    cls = BIT_PASS;
    if (bus.i_destuff_en) cls = (run_cnt_q == STUFF_CNT) ? BIT_STUFF : BIT_DATA;
  end

  // Next-state for run tracking, strobes, sticky error and idle counter.
  always_comb begin
    run_cnt_d   = run_cnt_q;
    run_val_d   = run_val_q;
    bit_valid_d = 1'b0;
    bit_d       = bit_q;
    stuff_bit_d = 1'b0;
    viol        = 1'b0;
    idle_cnt_d  = idle_cnt_q;
    if (bus.i_samp_tick) begin
      case (cls)
        BIT_PASS: begin
          run_cnt_d   = '0;
          bit_valid_d = 1'b1;
          bit_d       = rx;
        end
        BIT_DATA: begin
          bit_valid_d = 1'b1;
          bit_d       = rx;
          if (run_cnt_q == 3'd0 || rx != run_val_q) begin
            run_cnt_d = 3'd1;
            run_val_d = rx;
          end else begin
            run_cnt_d = run_cnt_q + 3'd1;
          end
        end
        default: begin
          // The stuff bit itself opens the next run whatever its polarity.
          stuff_bit_d = 1'b1;
          viol        = (rx == run_val_q);
          run_cnt_d   = 3'd1;
          run_val_d   = rx;
        end
      endcase
      if (rx) idle_cnt_d = (idle_cnt_q == IDLE_CNT) ? idle_cnt_q : idle_cnt_q + 4'd1;
      else    idle_cnt_d = '0;
    end
    // A fresh violation outranks a clear on the same cycle.
    stuff_err_d = viol | (stuff_err_q & ~bus.i_err_clr);
    bus_idle_d  = (idle_cnt_d == IDLE_CNT);
  end

  // State and output registers.
  always_ff @(posedge i_can_clk or negedge i_reset) begin
    if (!i_reset) begin
      run_cnt_q   <= '0;
      run_val_q   <= 1'b1;
      idle_cnt_q  <= '0;
      bit_valid_q <= 1'b0;
      bit_q       <= 1'b1;
      stuff_bit_q <= 1'b0;
      stuff_err_q <= 1'b0;
      bus_idle_q  <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      run_val_q   <= run_val_d;
      idle_cnt_q  <= idle_cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_q       <= bit_d;
      stuff_bit_q <= stuff_bit_d;
      stuff_err_q <= stuff_err_d;
      bus_idle_q  <= bus_idle_d;
    end
  end

  // Only emitted data bits are accumulated; stuff bits never reach the CRC.
  can_crc15 #(.POLY(CRC_POLY)) u_crc (
    .i_can_clk (i_can_clk),
    .i_reset   (i_reset),
    .i_clr     (bus.i_crc_clr),
    .i_en      (bit_valid_d & bus.i_crc_en),
    .i_bit     (rx),
    .o_crc     (crc)
  );

  assign bus.o_bit_valid = bit_valid_q;
  assign bus.o_bit       = bit_q;
  assign bus.o_stuff_bit = stuff_bit_q;
  assign bus.o_stuff_err = stuff_err_q;
  assign bus.o_crc       = crc;
  assign bus.o_crc_zero  = (crc == '0);
  assign bus.o_bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_can_rx_destuff.sv
// Bench for can_rx_destuff: directed scenarios plus randomized streams checked
// against a sample-history reference model.
module tb_can_rx_destuff;
  import can_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  can_rx_destuff_if bus();

  can_rx_destuff dut (
    .i_can_clk (clk),
    .i_reset   (rst_n),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: samples of the current stuffed segment (since region entry,
  // reset or the last stuff bit), plus plain counters for errors and idle.
  bit          m_seg[$];
  logic        m_valid, m_bit, m_stuff, m_err;
  logic [14:0] m_crc;
  int          m_idle_run;

  wire [20:0] obs = {bus.o_bit_valid, bus.o_bit, bus.o_stuff_bit, bus.o_stuff_err,
                     bus.o_crc, bus.o_crc_zero, bus.o_bus_idle};

  function automatic logic [20:0] exp_vec();
    return {m_valid, m_bit, m_stuff, m_err, m_crc, (m_crc == 15'd0),
            (m_idle_run >= CAN_IDLE_BITS)};
  endfunction

  // Length of the run of equal bits at the end of the segment.
  function automatic int trail_eq();
    int n = 0;
    for (int i = m_seg.size() - 1; i >= 0; i--) begin
      if (m_seg[i] == m_seg[m_seg.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  // CRC as polynomial long division, one message bit at a time.
  function automatic logic [14:0] crc_add(input logic [14:0] r, input logic b);
    logic [15:0] t;
    t = {r, 1'b0};
    if (b ^ r[14]) t[14:0] = t[14:0] ^ CAN_CRC_POLY;
    return t[14:0];
  endfunction

  task automatic model_reset();
    m_seg.delete();
    m_valid = 1'b0; m_bit = 1'b1; m_stuff = 1'b0; m_err = 1'b0;
    m_crc = '0; m_idle_run = 0;
  endtask

  // Drive one sample-tick cycle (starting at a negedge) and advance the model.
  task automatic apply(input logic rx, input logic de, input logic ce,
                       input logic cc, input logic ec);
    logic set;
    bus.i_samp_tick = 1'b1; bus.i_rx_bit = rx; bus.i_destuff_en = de;
    bus.i_crc_en = ce; bus.i_crc_clr = cc; bus.i_err_clr = ec;
    m_valid = 1'b0; m_stuff = 1'b0; set = 1'b0;
    if (!de) begin
      m_seg.delete(); m_valid = 1'b1; m_bit = rx;
    end else if (trail_eq() == CAN_STUFF_LEN) begin
      m_stuff = 1'b1;
      set = (rx == m_seg[m_seg.size() - 1]);
      m_seg.delete(); m_seg.push_back(rx);
    end else begin
      m_valid = 1'b1; m_bit = rx; m_seg.push_back(rx);
    end
    if (set) m_err = 1'b1;
    else if (ec) m_err = 1'b0;
    if (cc) m_crc = '0;
    else if (m_valid && ce) m_crc = crc_add(m_crc, rx);
    if (rx) m_idle_run++;
    else m_idle_run = 0;
    @(negedge clk);
    bus.i_samp_tick = 1'b0; bus.i_crc_clr = 1'b0; bus.i_err_clr = 1'b0;
  endtask

  task automatic gap();
    m_valid = 1'b0; m_stuff = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_samp_tick = 1'b0; bus.i_rx_bit = 1'b1; bus.i_destuff_en = 1'b0;
    bus.i_crc_en = 1'b0; bus.i_crc_clr = 1'b0; bus.i_err_clr = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (obs !== 21'h080002 || obs !== exp_vec()) begin
      $display("FAIL reset: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (obs !== exp_vec()) begin
      $display("FAIL reset_release: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_stuff_ok();
    logic b;
    logic [6:0] pat;
    int nvalid = 0;
    pat = 7'b0000011;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      b = pat[6 - i];
      apply(b, 1'b1, 1'b0, 1'b0, 1'b0);
      if (bus.o_bit_valid) nvalid++;
      if (obs !== exp_vec()) begin
        $display("FAIL stuff_ok[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
      end
      vectors++;
    end
    if (nvalid !== 6) begin
      $display("FAIL stuff_ok_count: got %0d want 6", nvalid); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_stuff_err();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      if (obs !== exp_vec()) begin
        $display("FAIL stuff_err[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
      end
      vectors++;
    end
    repeat (3) gap();
    if (bus.o_stuff_err !== 1'b1 || obs !== exp_vec()) begin
      $display("FAIL stuff_err_hold: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    if (bus.o_stuff_err !== 1'b0 || obs !== exp_vec()) begin
      $display("FAIL stuff_err_clr: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_crc();
    logic [14:0] word;
    word = 15'h4599;
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    if (bus.o_crc !== 15'd0 || bus.o_bit_valid !== 1'b1 || obs !== exp_vec()) begin
      $display("FAIL crc_clr_same_cycle: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.o_crc !== 15'h4599 || obs !== exp_vec()) begin
      $display("FAIL crc_one: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    for (int i = 14; i >= 0; i--) apply(word[i], 1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.o_crc !== 15'd0 || bus.o_crc_zero !== 1'b1 || obs !== exp_vec()) begin
      $display("FAIL crc_residue: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.o_bus_idle !== (i >= 11) || obs !== exp_vec()) begin
        $display("FAIL idle[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
      end
      vectors++;
      if (i == 11) begin
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (bus.o_bus_idle !== 1'b0 || obs !== exp_vec()) begin
          $display("FAIL idle_drop: got %h want %h", obs, exp_vec()); miscompares++;
        end
        vectors++;
        i = 0;
        break;
      end
    end
    for (int i = 1; i <= 20; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) gap();
    if (bus.o_bus_idle !== 1'b1 || obs !== exp_vec()) begin
      $display("FAIL idle_saturate: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (bus.o_bus_idle !== 1'b0) begin
      $display("FAIL idle_sat_drop: got %b want 0", bus.o_bus_idle); miscompares++;
    end
    vectors++;
  endtask

  task automatic test_reset_midstream();
    logic [5:0] pat;
    pat = 6'b000001;
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.i_samp_tick = 1'b1; bus.i_rx_bit = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (obs !== exp_vec()) begin
      $display("FAIL reset_mid: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    bus.i_samp_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (obs !== exp_vec()) begin
      $display("FAIL reset_mid_release: got %h want %h", obs, exp_vec()); miscompares++;
    end
    vectors++;
    for (int i = 0; i < 6; i++) begin
      apply(pat[5 - i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (obs !== exp_vec()) begin
        $display("FAIL fresh_run[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
      end
      vectors++;
    end
    if (bus.o_stuff_bit !== 1'b1 || bus.o_stuff_err !== 1'b0) begin
      $display("FAIL fresh_run_stuff: got stuff=%b err=%b want 1 0",
               bus.o_stuff_bit, bus.o_stuff_err);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_random();
    logic b, de;
    b = 1'b1; de = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      if ($urandom_range(0, 40) == 0) de = ~de;
      apply(b, de, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 60) == 0),
            1'($urandom_range(0, 20) == 0));
      if (obs !== exp_vec()) begin
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
      end
      vectors++;
      if ($urandom_range(0, 5) == 0) begin
        gap();
        if (obs !== exp_vec()) begin
          $display("FAIL random_gap[%0d]: got %h want %h", i, obs, exp_vec()); miscompares++;
        end
        vectors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stuff_ok();
    test_stuff_err();
    test_crc();
    test_idle();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
